// File: rtl/ahb_slave_interconnect_pkg.sv
// Shared types for the AHB-Lite slave interconnect.
//   ahbic_state_t : default-slave response sequencing states
//   ahbic_err_t   : codes stored in the error record (ErrCode)
//   sel_count     : number of set bits in a decoder select vector
package ahb_slave_interconnect_pkg;

  typedef enum logic [1:0] {
    AHBIC_OK   = 2'd0,
    AHBIC_ERR1 = 2'd1,
    AHBIC_ERR2 = 2'd2
  } ahbic_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNMAPPED = 2'b01,
    ERR_MULTI    = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } ahbic_err_t;

  // Select vectors are at most 16 wide; callers zero-extend.
  function automatic logic [4:0] sel_count(input logic [15:0] sel);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, sel[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ahb_slave_interconnect_default.sv
// Internal default slave: produces the two-cycle AHB ERROR response.
// Ports:
//   i_clk, i_rst_n : bus clock, asynchronous active-low reset
//   i_fault        : start an ERROR response (faulted address phase or watchdog abort)
//   o_hready       : default-slave HREADYOUT
//   o_hresp        : default-slave HRESP
//   o_state        : current FSM state (debug / checker visibility)
// When idle (OK) the default slave answers zero-wait OKAY.
module ahb_default_slave
  import ahb_slave_interconnect_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_fault,
  output logic       o_hready,
  output logic       o_hresp,
  output logic [1:0] o_state
);

  localparam logic [1:0] S_OK   = 2'(AHBIC_OK);
  localparam logic [1:0] S_ERR1 = 2'(AHBIC_ERR1);
  localparam logic [1:0] S_ERR2 = 2'(AHBIC_ERR2);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;

  // A fault can only arrive while HREADY is high (OK or ERR2) or from the
  // watchdog while a real slave owns the data phase (state OK), so ERR1 is
  // never interrupted and always runs ERR1 -> ERR2.
  always_comb begin
    w_state_nxt = r_state;
    if (i_fault) begin
      w_state_nxt = S_ERR1;
    end else begin
      case (r_state)
        S_ERR1:  w_state_nxt = S_ERR2;
        S_ERR2:  w_state_nxt = S_OK;
        default: w_state_nxt = S_OK;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_OK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign o_hready = (r_state != S_ERR1);
  assign o_hresp  = (r_state != S_OK);
  assign o_state  = r_state;

endmodule

// File: rtl/ahb_slave_interconnect.sv
// AHB-Lite single-master, N-slave data-phase interconnect.
// Routes HRDATA/HREADY/HRESP of the slave owning the data phase back to the
// master; unmapped, multi-select and hung-slave transfers are answered by an
// internal default slave with a two-cycle ERROR. A per-transfer watchdog
// aborts a slave that holds HREADYOUT low for TIMEOUT cycles and isolates it.
// Ports:
//   HCLK, HRESETn          : clock, asynchronous active-low reset
//   HADDR, HTRANS, HSELIN  : master address phase and decoder selects
//   HSELS                  : selects forwarded to slaves
//   HRDATAS/HREADYOUTS/HRESPS : per-slave data-phase outputs
//   HRDATA/HREADY/HRESP    : muxed data-phase outputs to master and slaves
//   ClearErr               : clears ErrValid and HungMask
//   ErrValid/ErrCode/ErrSlave/ErrAddr : sticky first-error record
//   HungMask               : slaves isolated after a watchdog abort
// Handshake: an address phase is accepted on a rising HCLK edge where
// HREADY=1 and HTRANS[1]=1; the data phase then completes on the first edge
// with HREADY=1. HREADY low stalls both the master and every slave.
module ahb_slave_interconnect
  import ahb_slave_interconnect_pkg::*;
#(
  parameter int NSLV    = 8,
  parameter int DW      = 64,
  parameter int AW      = 34,
  parameter int TIMEOUT = 255
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [AW-1:0]      HADDR,
  input  logic [1:0]         HTRANS,
  input  logic [NSLV-1:0]    HSELIN,
  output logic [NSLV-1:0]    HSELS,
  input  logic [NSLV*DW-1:0] HRDATAS,
  input  logic [NSLV-1:0]    HREADYOUTS,
  input  logic [NSLV-1:0]    HRESPS,
  output logic [DW-1:0]      HRDATA,
  output logic               HREADY,
  output logic               HRESP,
  input  logic               ClearErr,
  output logic               ErrValid,
  output logic [1:0]         ErrCode,
  output logic [3:0]         ErrSlave,
  output logic [AW-1:0]      ErrAddr,
  output logic [NSLV-1:0]    HungMask
);

  // Data-phase owner index; value NSLV denotes the default slave.
  localparam int              SW           = $clog2(NSLV + 1);
  localparam logic [SW-1:0]   DSEL_DEFAULT = SW'(NSLV);
  localparam int              CW           = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The abort fires on the TIMEOUT-th consecutive wait cycle, so the master
  // sees exactly TIMEOUT wait cycles before ERR1.
  localparam logic [CW-1:0]   CNT_LAST     = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [SW-1:0]   r_dsel;
  logic [AW-1:0]   r_addr;
  logic [CW-1:0]   r_cnt;
  logic [NSLV-1:0] r_hung;
  logic            r_err_valid;
  ahbic_err_t      r_err_code;
  logic [SW-1:0]   r_err_slave;
  logic [AW-1:0]   r_err_addr;

  logic [4:0]      w_nsel;
  logic            w_multi;
  logic            w_sel_hung;
  logic [SW-1:0]   w_sel_idx;
  logic            w_act;
  ahbic_err_t      w_addr_code;
  logic            w_addr_fault;
  logic            w_slv_valid;
  logic [DW-1:0]   w_slv_rdata;
  logic            w_slv_ready;
  logic            w_slv_resp;
  logic            w_wait;
  logic            w_timeout;
  logic            w_fault;
  ahbic_err_t      w_new_code;
  logic [SW-1:0]   w_new_slave;
  logic [AW-1:0]   w_new_addr;
  logic [NSLV-1:0] w_dsel_onehot;
  logic            w_dflt_hready;
  logic            w_dflt_hresp;
  logic [1:0]      w_dflt_state;
  logic            w_unused;

  assign w_unused = HTRANS[0];

  // ---------------- address-phase decode ----------------
  assign w_nsel     = sel_count(16'(HSELIN));
  assign w_multi    = (w_nsel > 5'd1);
  assign w_sel_hung = (w_nsel == 5'd1) && ((HSELIN & r_hung) != '0);
  assign w_act      = HREADY & HTRANS[1];

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (HSELIN[i]) w_sel_idx = SW'(i);
    end
  end

  always_comb begin
    w_addr_code = ERR_NONE;
    if (w_nsel == 5'd0)  w_addr_code = ERR_UNMAPPED;
    else if (w_multi)    w_addr_code = ERR_MULTI;
    else if (w_sel_hung) w_addr_code = ERR_TIMEOUT;
  end

  assign w_addr_fault = w_act && (w_addr_code != ERR_NONE);
  assign HSELS        = w_multi ? '0 : (HSELIN & ~r_hung);

  // ---------------- data-phase mux ----------------
  always_comb begin
    w_slv_valid   = 1'b0;
    w_slv_rdata   = '0;
    w_slv_ready   = 1'b1;
    w_slv_resp    = 1'b0;
    w_dsel_onehot = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (r_dsel == SW'(i)) begin
        w_slv_valid      = 1'b1;
        w_slv_rdata      = HRDATAS[i*DW +: DW];
        w_slv_ready      = HREADYOUTS[i];
        w_slv_resp       = HRESPS[i];
        w_dsel_onehot[i] = 1'b1;
      end
    end
  end

  assign HRDATA = w_slv_rdata;
  assign HREADY = w_slv_valid ? w_slv_ready : w_dflt_hready;
  assign HRESP  = w_slv_valid ? w_slv_resp  : w_dflt_hresp;

  // ---------------- watchdog ----------------
  assign w_wait    = w_slv_valid & ~w_slv_ready;
  assign w_timeout = (TIMEOUT != 0) && w_wait && (r_cnt == CNT_LAST);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt <= '0;
    end else if ((TIMEOUT == 0) || !w_wait || w_timeout) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // ---------------- data-phase owner ----------------
  // A timeout and an accepted address phase are exclusive: the timeout needs
  // HREADY low, acceptance needs HREADY high.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dsel <= DSEL_DEFAULT;
      r_addr <= '0;
    end else begin
      if (w_timeout) begin
        r_dsel <= DSEL_DEFAULT;
      end else if (HREADY) begin
        r_dsel <= (w_act && !w_addr_fault) ? w_sel_idx : DSEL_DEFAULT;
      end
      if (HREADY) r_addr <= HADDR;
    end
  end

  // ---------------- error record and hung mask ----------------
  assign w_fault     = w_addr_fault | w_timeout;
  assign w_new_code  = w_timeout ? ERR_TIMEOUT : w_addr_code;
  assign w_new_slave = w_timeout ? r_dsel :
                       (w_addr_code == ERR_TIMEOUT) ? w_sel_idx : '0;
  assign w_new_addr  = w_timeout ? r_addr : HADDR;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_slave <= '0;
      r_err_addr  <= '0;
      r_hung      <= '0;
    end else begin
      // ClearErr together with a new fault keeps the new fault.
      if (w_fault && (!r_err_valid || ClearErr)) begin
        r_err_valid <= 1'b1;
        r_err_code  <= w_new_code;
        r_err_slave <= w_new_slave;
        r_err_addr  <= w_new_addr;
      end else if (ClearErr) begin
        r_err_valid <= 1'b0;
      end
      r_hung <= (ClearErr ? '0 : r_hung) | (w_timeout ? w_dsel_onehot : '0);
    end
  end

  assign ErrValid = r_err_valid;
  assign ErrCode  = r_err_code;
  assign ErrSlave = 4'(r_err_slave);
  assign ErrAddr  = r_err_addr;
  assign HungMask = r_hung;

  ahb_default_slave u_default (
    .i_clk    (HCLK),
    .i_rst_n  (HRESETn),
    .i_fault  (w_fault),
    .o_hready (w_dflt_hready),
    .o_hresp  (w_dflt_hresp),
    .o_state  (w_dflt_state)
  );

endmodule

// File: tb/tb_ahb_slave_interconnect.sv
module tb_ahb_slave_interconnect;

  localparam int NSLV    = 8;
  localparam int DW      = 64;
  localparam int AW      = 34;
  localparam int TIMEOUT = 4;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  // ---------------- clock / reset / DUT ----------------
  logic               HCLK = 1'b0;
  logic               HRESETn;
  logic [AW-1:0]      HADDR;
  logic [1:0]         HTRANS;
  logic [NSLV-1:0]    HSELIN;
  logic [NSLV-1:0]    HSELS;
  logic [NSLV*DW-1:0] HRDATAS;
  logic [NSLV-1:0]    HREADYOUTS;
  logic [NSLV-1:0]    HRESPS;
  logic [DW-1:0]      HRDATA;
  logic               HREADY;
  logic               HRESP;
  logic               ClearErr;
  logic               ErrValid;
  logic [1:0]         ErrCode;
  logic [3:0]         ErrSlave;
  logic [AW-1:0]      ErrAddr;
  logic [NSLV-1:0]    HungMask;

  always #5 HCLK = ~HCLK;

  ahb_slave_interconnect #(.NSLV(NSLV), .DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSELIN(HSELIN), .HSELS(HSELS), .HRDATAS(HRDATAS), .HREADYOUTS(HREADYOUTS),
    .HRESPS(HRESPS), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .ClearErr(ClearErr), .ErrValid(ErrValid), .ErrCode(ErrCode), .ErrSlave(ErrSlave),
    .ErrAddr(ErrAddr), .HungMask(HungMask)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: who owns the current data phase (-1 = nobody/default),
  // how many ERROR cycles remain, how long the owner has stalled so far.
  int              m_owner;
  int              m_err_left;
  int              m_waits;
  logic [AW-1:0]   m_addr;
  logic [NSLV-1:0] m_hung;
  logic            m_valid;
  logic [1:0]      m_code;
  logic [3:0]      m_slave;
  logic [AW-1:0]   m_eaddr;

  logic            e_ready, e_resp;
  logic [DW-1:0]   e_data;
  logic [NSLV-1:0] e_hsels;

  task automatic model_reset();
    m_owner = -1; m_err_left = 0; m_waits = 0; m_addr = '0; m_hung = '0;
    m_valid = 1'b0; m_code = 2'd0; m_slave = 4'd0; m_eaddr = '0;
  endtask

  task automatic model_expect();
    if (m_owner >= 0) begin
      e_ready = HREADYOUTS[m_owner];
      e_resp  = HRESPS[m_owner];
      e_data  = HRDATAS[m_owner*DW +: DW];
    end else begin
      e_data  = '0;
      e_ready = (m_err_left != 2);
      e_resp  = (m_err_left != 0);
    end
    e_hsels = ($countones(HSELIN) > 1) ? '0 : (HSELIN & ~m_hung);
  endtask

  // Applies one clock edge to the model, using the inputs and the HREADY
  // value that were present just before the edge.
  task automatic model_edge();
    bit              fault;
    logic [1:0]      code;
    int              slave;
    logic [AW-1:0]   faddr;
    logic [NSLV-1:0] new_hung;
    int              ones, idx;
    fault = 0; code = 0; slave = 0; faddr = '0; new_hung = '0;
    if (m_owner >= 0 && !e_ready) begin
      m_waits++;
      if (TIMEOUT != 0 && m_waits == TIMEOUT) begin
        fault = 1; code = 2'd3; slave = m_owner; faddr = m_addr;
        new_hung[m_owner] = 1'b1;
        m_owner = -1; m_waits = 0;
      end
    end else begin
      m_waits = 0;
    end
    if (e_ready) begin
      m_addr  = HADDR;
      m_owner = -1;
      if (HTRANS[1]) begin
        ones = $countones(HSELIN);
        idx  = 0;
        for (int i = 0; i < NSLV; i++) if (HSELIN[i]) idx = i;
        faddr = HADDR;
        if (ones == 0)                 begin fault = 1; code = 2'd1; end
        else if (ones > 1)             begin fault = 1; code = 2'd2; end
        else if ((HSELIN & m_hung) != 0) begin fault = 1; code = 2'd3; slave = idx; end
        else                           m_owner = idx;
      end
    end
    if (fault) m_err_left = 2;
    else if (m_err_left > 0) m_err_left--;
    if (fault && (!m_valid || ClearErr)) begin
      m_valid = 1'b1; m_code = code; m_slave = 4'(slave); m_eaddr = faddr;
    end else if (ClearErr) begin
      m_valid = 1'b0;
    end
    m_hung = (ClearErr ? '0 : m_hung) | new_hung;
  endtask

  // ---------------- driver ----------------
  logic [DW-1:0]   nxt_data [NSLV];
  logic [NSLV-1:0] nxt_resp;

  task automatic cycle(input logic [NSLV-1:0] sel, input logic [1:0] trans,
                       input logic [NSLV-1:0] rdy, input logic [AW-1:0] addr,
                       input logic clr);
    @(negedge HCLK);
    HSELIN = sel; HTRANS = trans; HREADYOUTS = rdy; HADDR = addr; ClearErr = clr;
    HRESPS = nxt_resp;
    for (int i = 0; i < NSLV; i++) HRDATAS[i*DW +: DW] = nxt_data[i];
    #1;
    model_expect();
    check("hready",   64'(HREADY),   64'(e_ready));
    check("hresp",    64'(HRESP),    64'(e_resp));
    check("hrdata",   HRDATA,        e_data);
    check("hsels",    64'(HSELS),    64'(e_hsels));
    check("errvalid", 64'(ErrValid), 64'(m_valid));
    check("errcode",  64'(ErrCode),  64'(m_code));
    check("errslave", 64'(ErrSlave), 64'(m_slave));
    check("erraddr",  64'(ErrAddr),  64'(m_eaddr));
    check("hungmask", 64'(HungMask), 64'(m_hung));
    @(posedge HCLK);
    model_edge();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [NSLV-1:0] sel;
    logic [1:0]      trans;
    logic [NSLV-1:0] rdy;
    logic [AW-1:0]   addr;
    logic            exp_ready;
    logic            exp_resp;
    logic [NSLV-1:0] exp_hsels;
    logic [DW-1:0]   exp_data;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    // slave 2 waits twice then returns data; unmapped; multi-select (record kept)
    tbl[0]  = '{8'h04, T_NONSEQ, 8'hFF, 34'h100,  1'b1, 1'b0, 8'h04, 64'h0};
    tbl[1]  = '{8'h00, T_IDLE,   8'hFB, 34'h0,    1'b0, 1'b0, 8'h00, 64'hDEAD_BEEF};
    tbl[2]  = '{8'h00, T_IDLE,   8'hFB, 34'h0,    1'b0, 1'b0, 8'h00, 64'hDEAD_BEEF};
    tbl[3]  = '{8'h00, T_IDLE,   8'hFF, 34'h0,    1'b1, 1'b0, 8'h00, 64'hDEAD_BEEF};
    tbl[4]  = '{8'h00, T_NONSEQ, 8'hFF, 34'h1234, 1'b1, 1'b0, 8'h00, 64'h0};
    tbl[5]  = '{8'h00, T_IDLE,   8'hFF, 34'h0,    1'b0, 1'b1, 8'h00, 64'h0};
    tbl[6]  = '{8'h00, T_IDLE,   8'hFF, 34'h0,    1'b1, 1'b1, 8'h00, 64'h0};
    tbl[7]  = '{8'h00, T_IDLE,   8'hFF, 34'h0,    1'b1, 1'b0, 8'h00, 64'h0};
    tbl[8]  = '{8'h03, T_NONSEQ, 8'hFF, 34'h40,   1'b1, 1'b0, 8'h00, 64'h0};
    tbl[9]  = '{8'h00, T_IDLE,   8'hFF, 34'h0,    1'b0, 1'b1, 8'h00, 64'h0};
    tbl[10] = '{8'h00, T_IDLE,   8'hFF, 34'h0,    1'b1, 1'b1, 8'h00, 64'h0};
    tbl[11] = '{8'h00, T_IDLE,   8'hFF, 34'h0,    1'b1, 1'b0, 8'h00, 64'h0};

    for (int i = 0; i < NSLV; i++) nxt_data[i] = {32'hA5A5_0000, 32'(i) + 32'h100};
    nxt_data[2] = 64'hDEAD_BEEF;
    nxt_resp    = '0;

    // --- reset applied mid-cycle with all slaves stalling ---
    HRESETn = 1'b1; HADDR = '0; HTRANS = T_IDLE; HSELIN = '0; HRDATAS = '0;
    HREADYOUTS = '0; HRESPS = '0; ClearErr = 1'b0;
    model_reset();
    #2 HRESETn = 1'b0;
    #1;
    check("rst_hready",   64'(HREADY),   64'd1);
    check("rst_hresp",    64'(HRESP),    64'd0);
    check("rst_hrdata",   HRDATA,        64'd0);
    check("rst_errvalid", 64'(ErrValid), 64'd0);
    check("rst_errcode",  64'(ErrCode),  64'd0);
    check("rst_errslave", 64'(ErrSlave), 64'd0);
    check("rst_erraddr",  64'(ErrAddr),  64'd0);
    check("rst_hungmask", 64'(HungMask), 64'd0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    model_reset();

    // --- table ---
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].sel, tbl[i].trans, tbl[i].rdy, tbl[i].addr, 1'b0);
      check($sformatf("tbl%0d_hready", i), 64'(HREADY === 1'bx ? 1'b0 : e_ready), 64'(tbl[i].exp_ready));
      check($sformatf("tbl%0d_hresp", i),  64'(e_resp),  64'(tbl[i].exp_resp));
      check($sformatf("tbl%0d_hsels", i),  64'(e_hsels), 64'(tbl[i].exp_hsels));
      check($sformatf("tbl%0d_hrdata", i), e_data,       tbl[i].exp_data);
    end
    #1;
    check("unmapped_kept_code", 64'(ErrCode), 64'd1);
    check("unmapped_kept_addr", 64'(ErrAddr), 64'h1234);

    // --- multi-select after clear; clear+fault same cycle; clear during ERR1 ---
    cycle(8'h00, T_IDLE, 8'hFF, 34'h0, 1'b1);
    cycle(8'h03, T_NONSEQ, 8'hFF, 34'h2000, 1'b0);
    check("multi_hsels", 64'(HSELS), 64'd0);
    cycle(8'h00, T_IDLE, 8'hFF, 34'h0, 1'b0);
    cycle(8'h00, T_IDLE, 8'hFF, 34'h0, 1'b0);
    #1;
    check("multi_code", 64'(ErrCode), 64'd2);
    check("multi_addr", 64'(ErrAddr), 64'h2000);
    cycle(8'h00, T_NONSEQ, 8'hFF, 34'h777, 1'b1);
    #1;
    check("clrfault_valid", 64'(ErrValid), 64'd1);
    check("clrfault_code",  64'(ErrCode),  64'd1);
    check("clrfault_addr",  64'(ErrAddr),  64'h777);
    cycle(8'h00, T_IDLE, 8'hFF, 34'h0, 1'b1);
    check("clr_err1_hready", 64'(HREADY), 64'd0);
    cycle(8'h00, T_IDLE, 8'hFF, 34'h0, 1'b0);
    check("clr_err2_hready", 64'(HREADY), 64'd1);
    check("clr_err2_hresp",  64'(HRESP),  64'd1);

    // --- watchdog on slave 5 ---
    cycle(8'h20, T_NONSEQ, 8'hFF, 34'h5500, 1'b0);
    for (int w = 0; w < TIMEOUT; w++) begin
      cycle(8'h00, T_IDLE, 8'hDF, 34'h0, 1'b0);
      check($sformatf("wd_wait%0d_hready", w), 64'(HREADY), 64'd0);
      check($sformatf("wd_wait%0d_hresp", w),  64'(HRESP),  64'd0);
    end
    cycle(8'h00, T_IDLE, 8'hDF, 34'h0, 1'b0);
    check("wd_err1_hready", 64'(HREADY), 64'd0);
    check("wd_err1_hresp",  64'(HRESP),  64'd1);
    cycle(8'h00, T_IDLE, 8'hFF, 34'h0, 1'b0);
    check("wd_err2_hready", 64'(HREADY), 64'd1);
    check("wd_err2_hresp",  64'(HRESP),  64'd1);
    check("wd_hungmask", 64'(HungMask), 64'h20);
    check("wd_code",     64'(ErrCode),  64'd3);
    check("wd_slave",    64'(ErrSlave), 64'd5);
    check("wd_addr",     64'(ErrAddr),  64'h5500);
    cycle(8'h20, T_NONSEQ, 8'hFF, 34'h5508, 1'b0);
    check("hung_hsels", 64'(HSELS), 64'd0);
    cycle(8'h00, T_IDLE, 8'hFF, 34'h0, 1'b0);
    check("hung_err1_hresp", 64'(HRESP), 64'd1);
    cycle(8'h00, T_IDLE, 8'hFF, 34'h0, 1'b0);
    cycle(8'h00, T_IDLE, 8'hFF, 34'h0, 1'b1);
    #1;
    check("clr_hungmask", 64'(HungMask), 64'd0);
    cycle(8'h20, T_NONSEQ, 8'hFF, 34'h5510, 1'b0);
    check("unhung_hsels", 64'(HSELS), 64'h20);
    cycle(8'h00, T_IDLE, 8'hFF, 34'h0, 1'b0);
    check("unhung_hready", 64'(HREADY), 64'd1);
    check("unhung_hresp",  64'(HRESP),  64'd0);
    check("unhung_hrdata", HRDATA, 64'hA5A5_0000_0000_0105);

    // --- randomized traffic against the model ---
    for (int n = 0; n < 800; n++) begin
      logic [NSLV-1:0] sel, rdy;
      logic [1:0]      trans;
      int              r, a, b;
      r = $urandom_range(0, 9);
      a = $urandom_range(0, NSLV - 1);
      b = (a + $urandom_range(1, NSLV - 1)) % NSLV;
      sel = '0;
      if (r >= 2) sel[a] = 1'b1;
      if (r == 2 || r == 3) sel[b] = 1'b1;
      trans = 2'($urandom_range(0, 3));
      for (int i = 0; i < NSLV; i++) begin
        rdy[i]      = ($urandom_range(0, 3) != 0);
        nxt_resp[i] = ($urandom_range(0, 9) == 0);
        nxt_data[i] = {32'($urandom), 32'($urandom)};
      end
      cycle(sel, trans, rdy, {2'($urandom), 32'($urandom)}, ($urandom_range(0, 24) == 0));
    end

    // --- asynchronous reset during ERR1 ---
    nxt_resp = '0;
    cycle(8'h00, T_NONSEQ, 8'hFF, 34'h99, 1'b0);
    cycle(8'h00, T_NONSEQ, 8'hFF, 34'h9C, 1'b0);
    @(negedge HCLK);
    HTRANS = T_IDLE; HSELIN = '0; ClearErr = 1'b0;
    #1;
    model_expect();
    check("pre_rst_hready", 64'(HREADY), 64'(e_ready));
    check("pre_rst_hresp",  64'(HRESP),  64'(e_resp));
    check("pre_rst_valid",  64'(ErrValid), 64'd1);
    HRESETn = 1'b0;
    #1;
    check("async_rst_hready",   64'(HREADY),   64'd1);
    check("async_rst_hresp",    64'(HRESP),    64'd0);
    check("async_rst_errvalid", 64'(ErrValid), 64'd0);
    check("async_rst_errcode",  64'(ErrCode),  64'd0);
    check("async_rst_hungmask", 64'(HungMask), 64'd0);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    model_reset();
    cycle(8'h04, T_NONSEQ, 8'hFF, 34'h10, 1'b0);
    cycle(8'h00, T_IDLE, 8'hFF, 34'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
